// File: rtl/ram_read_checker.sv
// Read-back verifier: sweeps RAM and ROM in lockstep, compares the returned words
// after the read latency, and reports the mismatch count and the first failing address.
//
// state | meaning
// IDLE  | waiting for start, results of the last scan held
// READ  | issuing one address per cycle, 0..DEPTH-1
// DRAIN | reads stopped, waiting for in-flight compares to finish
// DONE  | one-cycle done pulse, results valid
module ram_read_checker #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 1024,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              ram_rd_en,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic [DATA_W-1:0] rom_rdata,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W:0]   err_cnt,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic              first_err_vld
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              ram_rd_en_q, ram_rd_en_d;
    logic              pass_q, pass_d;
    logic [ADDR_W:0]   err_cnt_q, err_cnt_d;
    logic [ADDR_W-1:0] first_err_addr_q, first_err_addr_d;
    logic              first_err_vld_q, first_err_vld_d;

    // Stage RD_LAT-1 lines up with the data returned for the address it carries.
    logic [RD_LAT-1:0] pipe_vld_q, pipe_vld_d;
    logic [ADDR_W-1:0] pipe_addr_q [RD_LAT];
    logic [ADDR_W-1:0] pipe_addr_d [RD_LAT];

    logic issue;
    logic mismatch;

    always_comb begin
        state_d          = state_q;
        mem_addr_d       = mem_addr_q;
        ram_rd_en_d      = ram_rd_en_q;
        pass_d           = pass_q;
        err_cnt_d        = err_cnt_q;
        first_err_addr_d = first_err_addr_q;
        first_err_vld_d  = first_err_vld_q;
        pipe_vld_d       = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            pipe_addr_d[i] = '0;
        end

        issue          = (state_q == S_READ);
        pipe_vld_d[0]  = issue;
        pipe_addr_d[0] = mem_addr_q;
        for (int i = 1; i < RD_LAT; i++) begin
            pipe_vld_d[i]  = pipe_vld_q[i-1];
            pipe_addr_d[i] = pipe_addr_q[i-1];
        end

        mismatch = pipe_vld_q[RD_LAT-1] && (ram_rdata != rom_rdata);
        if (mismatch) begin
            err_cnt_d = err_cnt_q + 1'b1;
            if (!first_err_vld_q) begin
                first_err_addr_d = pipe_addr_q[RD_LAT-1];
                first_err_vld_d  = 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d          = S_READ;
                    mem_addr_d       = '0;
                    ram_rd_en_d      = 1'b1;
                    err_cnt_d        = '0;
                    pass_d           = 1'b0;
                    first_err_vld_d  = 1'b0;
                    first_err_addr_d = '0;
                end
            end
            S_READ: begin
                if (mem_addr_q == LAST_ADDR) begin
                    state_d     = S_DRAIN;
                    ram_rd_en_d = 1'b0;
                end else begin
                    mem_addr_d = mem_addr_q + 1'b1;
                end
            end
            S_DRAIN: begin
                // Leave once the compare happening on this edge is the last one in flight.
                if (pipe_vld_d == '0) begin
                    state_d = S_DONE;
                    pass_d  = (err_cnt_d == '0);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= S_IDLE;
            mem_addr_q       <= '0;
            ram_rd_en_q      <= 1'b0;
            pass_q           <= 1'b0;
            err_cnt_q        <= '0;
            first_err_addr_q <= '0;
            first_err_vld_q  <= 1'b0;
            pipe_vld_q       <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_addr_q[i] <= '0;
            end
        end else begin
            state_q          <= state_d;
            mem_addr_q       <= mem_addr_d;
            ram_rd_en_q      <= ram_rd_en_d;
            pass_q           <= pass_d;
            err_cnt_q        <= err_cnt_d;
            first_err_addr_q <= first_err_addr_d;
            first_err_vld_q  <= first_err_vld_d;
            pipe_vld_q       <= pipe_vld_d;
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_addr_q[i] <= pipe_addr_d[i];
            end
        end
    end

    assign mem_addr       = mem_addr_q;
    assign ram_rd_en      = ram_rd_en_q;
    assign busy           = (state_q == S_READ) || (state_q == S_DRAIN);
    assign done           = (state_q == S_DONE);
    assign pass           = pass_q;
    assign err_cnt        = err_cnt_q;
    assign first_err_addr = first_err_addr_q;
    assign first_err_vld  = first_err_vld_q;

endmodule
